// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
//
// One pipeline register stage that carries an instruction/PC pair. It holds
// up to two entries: "main" drives the outputs, and "skid" catches the one
// entry that can still arrive after downstream stalls. Because of the skid
// entry, in_ready comes straight from a flop and never from out_ready.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high on that side. A producer holds its payload until it is accepted.
// The stage never withdraws out_valid or changes out_instr/out_pc while it is
// stalled. The only exceptions are flush and reset.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   in_valid     upstream entry valid
//   in_ready     stage can accept an entry this cycle (= !skid_valid)
//   in_instr     upstream instruction
//   in_pc        upstream PC
//   flush        discard both held entries and ignore this cycle's input
//   out_valid    downstream entry valid (= main_valid)
//   out_ready    downstream accepts the entry
//   out_instr    main instruction, or BUBBLE_INSTR when empty
//   out_pc       main PC, or 0 when empty
//   out_noflush  copy of out_valid, kept for the decode stage
//   occupancy    number of held entries, 0..2
// ---------------------------------------------------------------------------
module pipe_skid_stage #(
  parameter int                 INSTR_W      = 32,
  parameter int                 PC_W         = 32,
  parameter logic [INSTR_W-1:0] BUBBLE_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_noflush,
  output logic [1:0]         occupancy
);

  logic               main_valid, main_valid_d;
  logic [INSTR_W-1:0] main_instr, main_instr_d;
  logic [PC_W-1:0]    main_pc, main_pc_d;
  logic               skid_valid, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr, skid_instr_d;
  logic [PC_W-1:0]    skid_pc, skid_pc_d;

  logic accept;
  logic deliver;

  // in_ready depends only on the skid flop, so out_ready cannot ripple
  // upstream through this stage.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign deliver  = main_valid && out_ready;

  // Next-state selection. Flush wins over everything. When skid holds an
  // entry, in_ready is low, so no new entry can arrive that cycle. The only
  // possible move is skid -> main on delivery.
  always_comb begin
    main_valid_d = main_valid;
    main_instr_d = main_instr;
    main_pc_d    = main_pc;
    skid_valid_d = skid_valid;
    skid_instr_d = skid_instr;
    skid_pc_d    = skid_pc;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid) begin
      if (deliver) begin
        main_instr_d = skid_instr;
        main_pc_d    = skid_pc;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid || deliver) begin
        main_valid_d = 1'b1;
        main_instr_d = in_instr;
        main_pc_d    = in_pc;
      end else begin
        // main is stalled; park the arriving entry in skid
        skid_valid_d = 1'b1;
        skid_instr_d = in_instr;
        skid_pc_d    = in_pc;
      end
    end else if (deliver) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_instr <= BUBBLE_INSTR;
      main_pc    <= '0;
      skid_valid <= 1'b0;
      skid_instr <= BUBBLE_INSTR;
      skid_pc    <= '0;
    end else begin
      main_valid <= main_valid_d;
      main_instr <= main_instr_d;
      main_pc    <= main_pc_d;
      skid_valid <= skid_valid_d;
      skid_instr <= skid_instr_d;
      skid_pc    <= skid_pc_d;
    end
  end

  // An empty stage presents a NOP bubble and PC 0. It does not expose stale data.
  assign out_valid   = main_valid;
  assign out_noflush = main_valid;
  assign out_instr   = main_valid ? main_instr : BUBBLE_INSTR;
  assign out_pc      = main_valid ? main_pc : '0;
  assign occupancy   = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_stage
//
// Self-checking bench for pipe_skid_stage. The reference model is a FIFO
// queue (exp_q) with capacity 2:
//   - accept  = in_valid and fewer than 2 entries held
//   - deliver = at least one entry held and out_ready
//   - flush empties the queue
// The expected outputs come from the head of the queue and its size.
// Inputs are driven 1 ns after the rising edge. Outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_pipe_skid_stage;

  localparam int          INSTR_W = 32;
  localparam int          PC_W    = 32;
  localparam logic [31:0] BUBBLE  = 32'h0000_0013;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               out_noflush;
  logic [1:0]         occupancy;

  // model entries are {instr, pc}
  logic [INSTR_W+PC_W-1:0] exp_q[$];

  int errors = 0;
  int checks = 0;

  pipe_skid_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_noflush (out_noflush),
    .occupancy   (occupancy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  // This task is called 1 ns after a rising edge. It drives one cycle of
  // inputs, waits for the edge, updates the model, and returns 1 ns later.
  task automatic tick(input logic v, input logic [INSTR_W-1:0] ins,
                      input logic [PC_W-1:0] p, input logic rdy, input logic fl);
    logic acc;
    logic del;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = p;
    out_ready = rdy;
    flush     = fl;
    acc = v && (exp_q.size() < 2);
    del = (exp_q.size() > 0) && rdy;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (del) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({ins, p});
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    tick(1'b0, '0, '0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_noflush !== 1'b0) begin errors++; $display("FAIL reset_out_noflush got=%0b exp=0", out_noflush); end
    checks++; if (out_instr !== BUBBLE) begin errors++; $display("FAIL reset_out_instr got=%h exp=%h", out_instr, BUBBLE); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
  endtask

  task automatic test_stream();
    logic [PC_W-1:0] pcs[3];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 32'hA000_0000 + 32'(i), pcs[i], 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_pc !== pcs[i]) begin
        errors++; $display("FAIL stream_out_pc[%0d] got=%0b/%h exp=1/%h", i, out_valid, out_pc, pcs[i]);
      end
      checks++; if (out_instr !== 32'hA000_0000 + 32'(i)) begin
        errors++; $display("FAIL stream_out_instr[%0d] got=%h exp=%h", i, out_instr, 32'hA000_0000 + 32'(i));
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got=%0b exp=1", i, in_ready); end
    end
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    tick(1'b1, 32'hB100, 32'h100, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd1 || out_pc !== 32'h100) begin
      errors++; $display("FAIL bp_first occ=%0d pc=%h exp occ=1 pc=100", occupancy, out_pc);
    end
    tick(1'b1, 32'hB104, 32'h104, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full occ=%0d in_ready=%0b exp occ=2 in_ready=0", occupancy, in_ready);
    end
    checks++; if (out_pc !== 32'h100 || out_instr !== 32'hB100) begin
      errors++; $display("FAIL bp_hold pc=%h instr=%h exp pc=100 instr=b100", out_pc, out_instr);
    end
    // offered while full: must not be taken
    tick(1'b1, 32'hB108, 32'h108, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd2 || out_pc !== 32'h100) begin
      errors++; $display("FAIL bp_stall occ=%0d pc=%h exp occ=2 pc=100", occupancy, out_pc);
    end
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    checks++; if (out_pc !== 32'h104 || out_instr !== 32'hB104 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      errors++; $display("FAIL bp_release pc=%h instr=%h rdy=%0b occ=%0d exp 104/b104/1/1", out_pc, out_instr, in_ready, occupancy);
    end
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++; $display("FAIL bp_empty valid=%0b occ=%0d exp 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    tick(1'b1, 32'hC1F0, 32'h1F0, 1'b0, 1'b0);
    tick(1'b1, 32'hC1F4, 32'h1F4, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_prefill occ=%0d exp=2", occupancy); end
    tick(1'b1, 32'hC200, 32'h200, 1'b1, 1'b1);
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_noflush !== 1'b0) begin
      errors++; $display("FAIL flush_clear occ=%0d valid=%0b noflush=%0b exp 0/0/0", occupancy, out_valid, out_noflush);
    end
    checks++; if (out_instr !== BUBBLE || out_pc !== 32'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_bubble instr=%h pc=%h rdy=%0b exp 13/0/1", out_instr, out_pc, in_ready);
    end
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_200 valid=%0b pc=%h exp valid=0", out_valid, out_pc); end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 32'hD300, 32'h300, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL areset_prefill occ=%0d exp=1", occupancy); end
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    // still well before the next rising edge
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL areset_now valid=%0b occ=%0d rdy=%0b exp 0/0/1", out_valid, occupancy, in_ready);
    end
    checks++; if (out_instr !== BUBBLE || out_pc !== 32'h0 || out_noflush !== 1'b0) begin
      errors++; $display("FAIL areset_data instr=%h pc=%h nf=%0b exp 13/0/0", out_instr, out_pc, out_noflush);
    end
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_survivor valid=%0b pc=%h exp 0", out_valid, out_pc); end
  endtask

  task automatic test_random();
    logic                    v, rdy, fl;
    logic [INSTR_W-1:0]      ins;
    logic [PC_W-1:0]         p;
    logic [INSTR_W+PC_W-1:0] head;
    int                      sz;
    for (int n = 0; n < 10000; n++) begin
      sz = exp_q.size();
      head = (sz > 0) ? exp_q[0] : {BUBBLE, 32'h0};
      checks++; if (out_valid !== (sz > 0) || out_noflush !== (sz > 0)) begin
        errors++; $display("FAIL rnd_valid cyc=%0d got=%0b/%0b exp=%0b", n, out_valid, out_noflush, sz > 0);
      end
      checks++; if (occupancy !== 2'(sz) || in_ready !== (sz < 2)) begin
        errors++; $display("FAIL rnd_occ cyc=%0d occ=%0d rdy=%0b exp occ=%0d rdy=%0b", n, occupancy, in_ready, sz, sz < 2);
      end
      checks++; if ({out_instr, out_pc} !== head) begin
        errors++; $display("FAIL rnd_data cyc=%0d got=%h/%h exp=%h/%h", n, out_instr, out_pc, head[63:32], head[31:0]);
      end
      v   = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 40) == 0);
      ins = $urandom;
      p   = $urandom;
      tick(v, ins, p, rdy, fl);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
